// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared constants, FSM encoding and sizing helpers for the GF(2^m) multiplier
package gf2m_pkg;
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/gf2m_mulx_trinomial.sv
// gf2m_mulx_trinomial: out = en ? p*x^I mod (x^WIDTH+x^K+1) : 0, single fold (I <= WIDTH-K)
module gf2m_mulx_trinomial #(
  parameter int WIDTH = 127,
  parameter int K = 1,
  parameter int I = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] r;
  if (I == 0) begin : g_id
    assign r = p;
  end else begin : g_fold
    logic [I-1:0] h;
    assign h = p[WIDTH-1 -: I];
    // x^WIDTH = x^K + 1: wrapped bits land at 0 (rotation) and again at K
    assign r = {p[WIDTH-1-I:0], h} ^ ({{(WIDTH-I){1'b0}}, h} << K);
  end
  assign out = en ? r : '0;
endmodule

// File: rtl/gf2m_mul_digit_mac.sv
// gf2m_mul_digit_mac: digit-serial MSB-first multiplier/MAC over GF(2^WIDTH), trinomial modulus
module gf2m_mul_digit_mac
  import gf2m_pkg::*;
#(
  parameter int WIDTH = 127,
  parameter int K = 1,
  parameter int D = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] op_c
);
  localparam int DIGIT_N = ceil_div(WIDTH, D);
  localparam int PAD = DIGIT_N * D;
  localparam int CW = DIGIT_N > 1 ? clog2(DIGIT_N) : 1;
  localparam int NP = 1 << clog2(D);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_N - 1);
  if (K < 1 || 2 * K >= WIDTH) begin : g_bad_k
    $error("gf2m_mul_digit_mac: K out of range 1 <= K < WIDTH/2");
  end
  if (D < 1 || D > WIDTH - K) begin : g_bad_d
    $error("gf2m_mul_digit_mac: D out of range 1 <= D <= WIDTH-K");
  end
  state_t state_q, state_d;
  logic [PAD-1:0] a_sh;
  logic [WIDTH-1:0] b, acc, c, c_sh, c_next;
  logic [CW-1:0] cnt;
  logic accept, last;
  logic [WIDTH-1:0] tree [2*NP-1];
  // leaves of a balanced XOR tree: one partial product per digit bit, zero padding to a power of two
  for (genvar i = 0; i < NP; i++) begin : g_pp
    if (i < D) begin : g_m
      gf2m_mulx_trinomial #(.WIDTH(WIDTH), .K(K), .I(i)) u_m (
        .en(a_sh[PAD-D+i]),
        .p(b),
        .out(tree[NP-1+i])
      );
    end else begin : g_z
      assign tree[NP-1+i] = '0;
    end
  end
  for (genvar n = 0; n < NP - 1; n++) begin : g_t
    assign tree[n] = tree[2*n+1] ^ tree[2*n+2];
  end
  gf2m_mulx_trinomial #(.WIDTH(WIDTH), .K(K), .I(D)) u_sh (
    .en(1'b1),
    .p(c),
    .out(c_sh)
  );
  assign c_next = c_sh ^ tree[0];
  assign busy = state_q == ST_RUN;
  always_comb begin
    accept = state_q == ST_IDLE && start;
    last = state_q == ST_RUN && cnt == LAST;
    state_d = accept ? ST_RUN : last ? ST_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      done <= 1'b0;
      op_c <= '0;
      a_sh <= '0;
      b <= '0;
      acc <= '0;
      c <= '0;
      cnt <= '0;
    end else begin
      state_q <= state_d;
      done <= last;
      if (accept) begin
        a_sh <= PAD'(op_a);
        b <= op_b;
        acc <= mode == MODE_MAC ? op_acc : '0;
        c <= '0;
        cnt <= '0;
      end else if (state_q == ST_RUN) begin
        a_sh <= a_sh << D;
        c <= c_next;
        cnt <= cnt + 1'b1;
        if (last) op_c <= c_next ^ acc;
      end
    end
  end
endmodule

// File: tb/tb_gf2m_mul_digit_mac.sv
// tb_gf2m_mul_digit_mac: random and directed checks of two configurations against a polynomial model
module tb_gf2m_mul_digit_mac;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  logic s_start = 1'b0, s_mode = 1'b0, s_busy, s_done;
  logic [6:0] s_a = '0, s_b = '0, s_acc = '0, s_c;
  logic l_start = 1'b0, l_mode = 1'b0, l_busy, l_done;
  logic [126:0] l_a = '0, l_b = '0, l_acc = '0, l_c;
  gf2m_mul_digit_mac #(.WIDTH(7), .K(1), .D(3)) u_s (
    .clk(clk), .rst_b(rst_b), .start(s_start), .mode(s_mode), .op_a(s_a), .op_b(s_b),
    .op_acc(s_acc), .busy(s_busy), .done(s_done), .op_c(s_c)
  );
  gf2m_mul_digit_mac #(.WIDTH(127), .K(1), .D(13)) u_l (
    .clk(clk), .rst_b(rst_b), .start(l_start), .mode(l_mode), .op_a(l_a), .op_b(l_b),
    .op_acc(l_acc), .busy(l_busy), .done(l_done), .op_c(l_c)
  );
  // schoolbook polynomial product, then reduce top-down with x^w = x^k + 1
  function automatic logic [126:0] gf_mul(input logic [126:0] a, input logic [126:0] b,
                                          input int w, input int k);
    logic [253:0] p = '0;
    for (int i = 0; i < w; i++) if (a[i]) p ^= 254'(b) << i;
    for (int i = 2 * w - 2; i >= w; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p[i-w+k] = ~p[i-w+k];
        p[i-w] = ~p[i-w];
      end
    return p[126:0];
  endfunction
  function automatic logic [126:0] rnd127();
    logic [127:0] t = {$urandom, $urandom, $urandom, $urandom};
    return t[126:0];
  endfunction
  task automatic chk(input string tag, input logic [126:0] got, input logic [126:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic s_op(input logic m, input logic [6:0] a, input logic [6:0] b,
                      input logic [6:0] acc, input logic [6:0] exp);
    int n = 0;
    logic [6:0] prev = s_c;
    s_start = 1'b1; s_mode = m; s_a = a; s_b = b; s_acc = acc;
    tick();
    s_start = 1'b0; s_mode = ~m; s_a = 7'($urandom); s_acc = 7'($urandom);
    chk("s_busy", 127'(s_busy), 127'(1));
    do begin
      chk("s_hold", 127'(s_c), 127'(prev));
      tick();
      n++;
    end while (!s_done && n < 10);
    chk("s_lat", 127'(n), 127'(3));
    chk("s_c", 127'(s_c), 127'(exp));
    tick();
    chk("s_done_pulse", 127'(s_done), 127'(0));
  endtask
  task automatic l_op(input logic m, input logic [126:0] a, input logic [126:0] b,
                      input logic [126:0] acc);
    int n = 0;
    logic [126:0] prev = l_c;
    logic [126:0] exp = gf_mul(a, b, 127, 1) ^ (m ? acc : '0);
    l_start = 1'b1; l_mode = m; l_a = a; l_b = b; l_acc = acc;
    tick();
    l_start = 1'b0; l_a = rnd127(); l_b = rnd127(); l_mode = ~m;
    do begin
      chk("l_hold", l_c, prev);
      tick();
      n++;
    end while (!l_done && n < 20);
    chk("l_lat", 127'(n), 127'(10));
    chk("l_c", l_c, exp);
  endtask
  initial begin
    logic [6:0] ta[4], tb[4], tacc[4], prev, exp;
    logic tm[4];
    repeat (2) tick();
    chk("rst_s_busy", 127'(s_busy), 127'(0));
    chk("rst_s_done", 127'(s_done), 127'(0));
    chk("rst_s_c", 127'(s_c), 127'(0));
    chk("rst_l_c", l_c, '0);
    @(negedge clk) rst_b = 1'b1;
    tick();
    s_op(1'b0, 7'h02, 7'h40, 7'h00, 7'h03);
    s_op(1'b1, 7'h02, 7'h40, 7'h03, 7'h00);
    s_op(1'b0, 7'h00, 7'h7F, 7'h55, 7'h00);
    s_op(1'b0, 7'h7F, 7'h7F, 7'h00, 7'(gf_mul(127'h7F, 127'h7F, 7, 1)));
    // start held high: ops every 4 cycles, inputs scrambled while busy
    for (int k = 0; k < 4; k++) begin
      ta[k] = 7'($urandom); tb[k] = 7'($urandom) | 7'h01; tacc[k] = 7'($urandom); tm[k] = 1'(k);
    end
    prev = s_c;
    s_start = 1'b1; s_a = ta[0]; s_b = tb[0]; s_acc = tacc[0]; s_mode = tm[0];
    tick();
    for (int k = 0; k < 4; k++) begin
      exp = 7'(gf_mul(127'(ta[k]), 127'(tb[k]), 7, 1)) ^ (tm[k] ? tacc[k] : 7'h00);
      s_a = 7'($urandom); s_b = 7'($urandom); s_acc = 7'($urandom); s_mode = 1'($urandom);
      chk("b2b_busy", 127'(s_busy), 127'(1));
      chk("b2b_hold", 127'(s_c), 127'(prev));
      tick();
      tick();
      chk("b2b_hold2", 127'(s_c), 127'(prev));
      tick();
      chk("b2b_done", 127'(s_done), 127'(1));
      chk("b2b_c", 127'(s_c), 127'(exp));
      prev = exp;
      if (k < 3) begin
        s_a = ta[k+1]; s_b = tb[k+1]; s_acc = tacc[k+1]; s_mode = tm[k+1];
      end else s_start = 1'b0;
      tick();
    end
    chk("b2b_idle", 127'(s_busy), 127'(0));
    // asynchronous reset during the second RUN cycle
    s_start = 1'b1; s_mode = 1'b0; s_a = 7'h5A; s_b = 7'h33;
    tick();
    s_start = 1'b0;
    tick();
    #2 rst_b = 1'b0;
    #1;
    chk("arst_busy", 127'(s_busy), 127'(0));
    chk("arst_done", 127'(s_done), 127'(0));
    chk("arst_c", 127'(s_c), 127'(0));
    @(negedge clk) rst_b = 1'b1;
    tick();
    chk("arst_no_done", 127'(s_done), 127'(0));
    s_op(1'b0, 7'h01, 7'h55, 7'h00, 7'h55);
    l_op(1'b0, {127{1'b1}}, {127{1'b1}}, '0);
    l_op(1'b1, 127'(1), {1'b1, 126'h0}, rnd127());
    for (int r = 0; r < 300; r++) l_op(1'($urandom), rnd127(), rnd127(), rnd127());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
